ltc2600_spi_responder: RTL and testbench
========================================

// Module: ltc2600_spi_responder
// PURPOSE
//  Synthesizable SPI-slave model of the LTC2600 octal 16-bit DAC, the receiving end of the DAC write path.
//  Decodes 24-bit frames (cmd[3:0], addr[3:0], data[DATA_WIDTH-1:0], MSB first) into input/DAC registers and power state.
//  Drives daisy-chain sdo. Used for on-board loopback self-test and as the reference responder in DAC-writer benches.
//  Runs in the writer's clock domain (sck == clk there), so sck has no port; sdi and csb are sampled on posedge clk.
// PARAMETERS
//  DATA_WIDTH   16   data field width; frame length FRAME_BITS = 8 + DATA_WIDTH
//  NUM_DACS     8    channels A..H, addressed 0..NUM_DACS-1
// PORTS
//  clk             in   1                     system clock; sdi/csb sampled on its rising edge
//  rstn            in   1                     async active-low reset
//  csb             in   1                     chip select, active low; frame = contiguous cycles with csb low
//  sdi             in   1                     serial data in, MSB first
//  clrb            in   1                     async active-low DAC clear, same as the device pin
//  sdo             out  1                     daisy-chain out = MSB of the 24-bit shift register
//  dac_value       out  NUM_DACS*DATA_WIDTH   DAC output registers; channel n at [n*DATA_WIDTH +: DATA_WIDTH]
//  dac_powered     out  NUM_DACS              1 = channel powered up
//  frame_valid     out  1                     1-cycle pulse: well-formed frame executed
//  frame_error     out  1                     1-cycle pulse: frame discarded (bit count != FRAME_BITS)
//  last_cmd        out  4                     command of last frame (valid or not), held
//  last_addr       out  4                     address of last frame, held
// BEHAVIOUR
//  Reset (rstn=0): all registers 0; sdo=0, dac_value=0, dac_powered=0, frame_valid/frame_error=0, last_cmd/addr=0, FSM=IDLE.
//  clrb=0: input and DAC registers cleared to 0 asynchronously; power state, FSM and shift register unaffected.
//  FSM IDLE: on posedge with csb=0, shift sdi in, bit_cnt<=1, go SHIFT.
//  FSM SHIFT: csb=0 -> shift sdi in, bit_cnt saturating increment (6 bits, saturates at 63); csb=1 -> go EXEC. The csb=1 cycle samples nothing.
//  FSM EXEC (1 cycle): bit_cnt==FRAME_BITS -> decode and frame_valid=1; else frame_error=1 and no register change.
//    Next state is IDLE if csb=1, or SHIFT with the first bit taken if csb=0 (back-to-back frames).
//  >FRAME_BITS bits -> frame_error; the shift register still holds the last 24 bits for sdo.
//  Decode: cmd 0000 write input[n]; 0001 DAC[n]<=input[n], power up n; 0010 write input[n], then all DAC<=input, power up all;
//    0011 write input[n] and DAC[n], power up n; 0100 power down n (DAC value retained); 1111 no-op; other cmd -> no-op, still frame_valid.
//  addr 0..NUM_DACS-1 selects n; 1111 selects all channels; any other addr -> no register change, still frame_valid.
//  Latency: dac_value/dac_powered/last_* update and the pulse asserts on the posedge after the first csb=1 sample. That is 2 clk after the writer raises csb.
//  sdo: shift register MSB, updated each shift. The previous frame appears on sdo 24 clk delayed, matching the device.
//  Simultaneous clrb=0 and EXEC writing DAC: clear wins; input/DAC stay 0 while clrb low; power updates still apply.
//  rstn deasserted mid-frame: partial frame lost; the next csb-low cycle starts a fresh frame.
// STRUCTURE
//  ltc2600_pkg: typedef enum logic[3:0] ltc2600_cmd_t (WRITE_N=0000, UPDATE_N=0001, WRITE_N_UPDATE_ALL=0010,
//    WRITE_UPDATE_N=0011, POWER_DOWN_N=0100, NOP=1111); ADDR_ALL=4'hF; FRAME_BITS. Shared with the DAC writer.
//  Sub-module ltc2600_spi_shift_rx: FSM + shift register + bit counter; outputs frame word, frame_done, bit_ok, sdo.
//  Top: command decode, input/DAC register arrays, power mask, pulses.
// TESTING
//  T1 frame cmd=0011 addr=2 data=0xABCD -> dac_value[2]=0xABCD, dac_powered=8'h04, one frame_valid pulse, others 0.
//  T2 0000 addr=5 0x1234, then 0001 addr=5 -> after 1st dac_value[5]=0; after 2nd =0x1234, powered[5]=1.
//  T3 0010 addr=F data=0x8000 -> all 8 channels 0x8000, dac_powered=8'hFF; then 0100 addr=3 -> powered=8'hF7, value kept.
//  T4 csb low 23 cycles then 25 cycles -> two frame_error pulses, no register change, last_cmd updated.
//  T5 back-to-back frames (csb high exactly 1 cycle) -> both execute; sdo during 2nd = 1st frame word, bit-exact.
//  T6 clrb pulse low after T3 -> all dac_value=0, dac_powered=8'hFF; rstn low mid-frame -> all outputs 0, next frame ok.

Source files
------------

// File: rtl/ltc2600_pkg.sv
// ltc2600_pkg: LTC2600 command encoding, frame geometry and receiver state codes
package ltc2600_pkg;
  typedef enum logic [3:0] {
    WRITE_N            = 4'b0000,
    UPDATE_N           = 4'b0001,
    WRITE_N_UPDATE_ALL = 4'b0010,
    WRITE_UPDATE_N     = 4'b0011,
    POWER_DOWN_N       = 4'b0100,
    NOP                = 4'b1111
  } ltc2600_cmd_t;
  localparam logic [3:0] ADDR_ALL = 4'hF;
  localparam int DATA_BITS = 16;
  localparam int FRAME_BITS = 8 + DATA_BITS;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction
endpackage

// File: rtl/ltc2600_spi_shift_rx.sv
// ltc2600_spi_shift_rx: frame receiver - shift register, saturating bit counter and IDLE/SHIFT/EXEC sequencing
module ltc2600_spi_shift_rx
  import ltc2600_pkg::*;
#(
  parameter int FB = FRAME_BITS
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_csb,
  input  logic          i_sdi,
  output logic [FB-1:0] o_frame,
  output logic          o_frame_done,
  output logic          o_bit_ok,
  output logic          o_sdo
);
  logic [1:0]    r_state;
  logic [FB-1:0] r_sr;
  logic [5:0]    r_cnt;
  // any csb-low cycle shifts a bit in; a fresh frame restarts the count at 1, csb high after a frame runs one EXEC cycle
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_sr <= '0;
      r_cnt <= '0;
    end else if (!i_csb) begin
      r_state <= ST_SHIFT;
      r_sr <= {r_sr[FB-2:0], i_sdi};
      r_cnt <= (r_state == ST_SHIFT) ? sat_inc6(r_cnt) : 6'd1;
    end else begin
      r_state <= (r_state == ST_SHIFT) ? ST_EXEC : ST_IDLE;
    end
  assign o_frame = r_sr;
  assign o_frame_done = (r_state == ST_EXEC);
  assign o_bit_ok = (r_cnt == 6'(FB));
  assign o_sdo = r_sr[FB-1];
endmodule

// File: rtl/ltc2600_spi_responder.sv
// ltc2600_spi_responder: LTC2600 SPI-slave model - decodes frames into input/DAC registers and power state
module ltc2600_spi_responder
  import ltc2600_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DACS = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           csb,
  input  logic                           sdi,
  input  logic                           clrb,
  output logic                           sdo,
  output logic [NUM_DACS*DATA_WIDTH-1:0] dac_value,
  output logic [NUM_DACS-1:0]            dac_powered,
  output logic                           frame_valid,
  output logic                           frame_error,
  output logic [3:0]                     last_cmd,
  output logic [3:0]                     last_addr
);
  localparam int FB = 8 + DATA_WIDTH;
  logic [FB-1:0]                         w_frame;
  logic                                  w_done, w_ok, w_exec, w_wr, w_all, w_arr_rst_n;
  logic [3:0]                            w_cmd, w_addr;
  logic [DATA_WIDTH-1:0]                 w_data;
  logic [NUM_DACS-1:0]                   w_sel, w_pwr_nx, r_pwr;
  logic [NUM_DACS-1:0][DATA_WIDTH-1:0]   r_in, r_dac, w_in_nx, w_dac_nx;
  logic                                  r_valid, r_error;
  logic [3:0]                            r_cmd, r_addr;
  ltc2600_spi_shift_rx #(.FB(FB)) u_rx (
    .clk         (clk),
    .rstn        (rstn),
    .i_csb       (csb),
    .i_sdi       (sdi),
    .o_frame     (w_frame),
    .o_frame_done(w_done),
    .o_bit_ok    (w_ok),
    .o_sdo       (sdo)
  );
  assign w_cmd = w_frame[FB-1 -: 4];
  assign w_addr = w_frame[FB-5 -: 4];
  assign w_data = w_frame[DATA_WIDTH-1:0];
  assign w_exec = w_done & w_ok;
  assign w_wr = (w_cmd == WRITE_N) || (w_cmd == WRITE_N_UPDATE_ALL) || (w_cmd == WRITE_UPDATE_N);
  assign w_all = (w_cmd == WRITE_N_UPDATE_ALL) && (|w_sel);
  // next input/DAC contents: an unmapped address gives an empty select mask and so changes nothing
  always_comb begin
    w_sel = '0;
    w_in_nx = r_in;
    w_dac_nx = r_dac;
    for (int n = 0; n < NUM_DACS; n++) begin
      w_sel[n] = (w_addr == ADDR_ALL) || (int'(w_addr) == n);
      w_in_nx[n] = (w_sel[n] && w_wr) ? w_data : r_in[n];
      w_dac_nx[n] = w_all ? w_in_nx[n] :
                    (w_sel[n] && w_cmd == UPDATE_N) ? r_in[n] :
                    (w_sel[n] && w_cmd == WRITE_UPDATE_N) ? w_data : r_dac[n];
    end
  end
  assign w_pwr_nx = w_all ? '1 :
                    (w_cmd == UPDATE_N || w_cmd == WRITE_UPDATE_N) ? (r_pwr | w_sel) :
                    (w_cmd == POWER_DOWN_N) ? (r_pwr & ~w_sel) : r_pwr;
  assign w_arr_rst_n = rstn & clrb;
  // input/DAC registers: clrb clears them asynchronously and holds them at zero, so it beats a concurrent write
  always_ff @(posedge clk or negedge w_arr_rst_n)
    if (!w_arr_rst_n) begin
      r_in <= '0;
      r_dac <= '0;
    end else if (w_exec) begin
      r_in <= w_in_nx;
      r_dac <= w_dac_nx;
    end
  // power mask, result pulses and last command/address; clrb does not touch these
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_pwr <= '0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
      r_cmd <= '0;
      r_addr <= '0;
    end else begin
      r_valid <= w_exec;
      r_error <= w_done & ~w_ok;
      if (w_exec) r_pwr <= w_pwr_nx;
      if (w_done) begin
        r_cmd <= w_cmd;
        r_addr <= w_addr;
      end
    end
  assign dac_value = r_dac;
  assign dac_powered = r_pwr;
  assign frame_valid = r_valid;
  assign frame_error = r_error;
  assign last_cmd = r_cmd;
  assign last_addr = r_addr;
endmodule

// File: tb/tb_ltc2600_spi_responder.sv
// tb_ltc2600_spi_responder: directed plus random frames checked against an array-based LTC2600 model
module tb_ltc2600_spi_responder;
  logic clk = 1'b0, rstn = 1'b0, csb = 1'b1, sdi = 1'b0, clrb = 1'b1;
  logic sdo, frame_valid, frame_error;
  logic [127:0] dac_value;
  logic [7:0] dac_powered;
  logic [3:0] last_cmd, last_addr;
  int ncmp = 0, nfail = 0, nv = 0, ne = 0, v0 = 0;
  logic [15:0] in_m [8];
  logic [15:0] dac_m [8];
  logic [7:0] pwr_m;
  logic [3:0] lc_m, la_m;
  logic [23:0] sr_m, w1;
  ltc2600_spi_responder #(.DATA_WIDTH(16), .NUM_DACS(8)) dut (
    .clk(clk), .rstn(rstn), .csb(csb), .sdi(sdi), .clrb(clrb), .sdo(sdo),
    .dac_value(dac_value), .dac_powered(dac_powered), .frame_valid(frame_valid),
    .frame_error(frame_error), .last_cmd(last_cmd), .last_addr(last_addr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    nv <= nv + int'(frame_valid);
    ne <= ne + int'(frame_error);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic mreset();
    for (int c = 0; c < 8; c++) begin in_m[c] = '0; dac_m[c] = '0; end
    pwr_m = '0; lc_m = '0; la_m = '0; sr_m = '0;
  endtask
  task automatic check_regs();
    for (int c = 0; c < 8; c++) chk($sformatf("dac%0d", c), 32'(dac_value[c*16 +: 16]), 32'(dac_m[c]));
    chk("powered", 32'(dac_powered), 32'(pwr_m));
    chk("last_cmd", 32'(last_cmd), 32'(lc_m));
    chk("last_addr", 32'(last_addr), 32'(la_m));
  endtask
  task automatic apply(input logic [23:0] w, input int n);
    logic [3:0] c, a;
    logic [15:0] d;
    logic [7:0] sel;
    c = w[23:20]; a = w[19:16]; d = w[15:0];
    lc_m = c; la_m = a;
    if (n != 24) return;
    sel = (a == 4'hF) ? 8'hFF : (a < 4'd8) ? 8'(1 << a) : 8'h00;
    for (int ch = 0; ch < 8; ch++)
      if (sel[ch])
        case (c)
          4'h0, 4'h2: in_m[ch] = d;
          4'h1: begin dac_m[ch] = in_m[ch]; pwr_m[ch] = 1'b1; end
          4'h3: begin in_m[ch] = d; dac_m[ch] = d; pwr_m[ch] = 1'b1; end
          4'h4: pwr_m[ch] = 1'b0;
          default: ;
        endcase
    if (c == 4'h2 && sel != 0) begin
      for (int ch = 0; ch < 8; ch++) dac_m[ch] = in_m[ch];
      pwr_m = 8'hFF;
    end
  endtask
  task automatic send(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      csb = 1'b0; sdi = v[n-1-i];
      chk("sdo", 32'(sdo), 32'(sr_m[23]));
      @(posedge clk); #1;
      sr_m = {sr_m[22:0], v[n-1-i]};
    end
    csb = 1'b1; sdi = 1'b0;
  endtask
  task automatic close(input bit ok);
    @(posedge clk); #1;
    chk("pulse_early", {frame_valid, frame_error}, 32'd0);
    @(posedge clk); #1;
    chk("pulse", {frame_valid, frame_error}, {ok, !ok});
    check_regs();
    @(posedge clk); #1;
    chk("pulse_end", {frame_valid, frame_error}, 32'd0);
  endtask
  task automatic frame(input logic [31:0] v, input int n);
    send(v, n);
    apply(sr_m, n);
    close(n == 24);
  endtask
  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d);
    return {8'h00, c, a, d};
  endfunction
  initial begin
    logic [3:0] rc, ra;
    int rn;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    check_regs();
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_pulse", {frame_valid, frame_error}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    frame(mk(4'h3, 4'd2, 16'hABCD), 24);
    chk("t1_val", 32'(dac_value[47:32]), 32'hABCD);
    chk("t1_pwr", 32'(dac_powered), 32'h04);
    frame(mk(4'h0, 4'd5, 16'h1234), 24);
    chk("t2_before", 32'(dac_value[95:80]), 32'h0);
    frame(mk(4'h1, 4'd5, 16'h0000), 24);
    chk("t2_after", 32'(dac_value[95:80]), 32'h1234);
    frame(mk(4'h2, 4'hF, 16'h8000), 24);
    chk("t3_pwr", 32'(dac_powered), 32'hFF);
    frame(mk(4'h4, 4'd3, 16'h0000), 24);
    chk("t3_pd", 32'(dac_powered), 32'hF7);
    chk("t3_keep", 32'(dac_value[63:48]), 32'h8000);
    frame(mk(4'h3, 4'd1, 16'h5555), 23);
    frame(32'h1_9F_7777, 25);
    frame(mk(4'h4, 4'd1, 16'h0000), 24);
    frame(mk(4'h3, 4'd9, 16'hDEAD), 24);
    frame(mk(4'h7, 4'd0, 16'hBEEF), 24);
    v0 = nv;
    send(mk(4'h3, 4'd6, 16'hC3A5), 24);
    w1 = sr_m;
    apply(w1, 24);
    @(posedge clk); #1;
    send(mk(4'h0, 4'd6, 16'h0F0F), 24);
    apply(sr_m, 24);
    close(1'b1);
    chk("t5_count", 32'(nv - v0), 32'd2);
    chk("t5_val", 32'(dac_value[111:96]), 32'hC3A5);
    frame(mk(4'h2, 4'hF, 16'h8000), 24);
    clrb = 1'b0;
    #2;
    for (int c = 0; c < 8; c++) begin in_m[c] = '0; dac_m[c] = '0; end
    check_regs();
    chk("t6_pwr", 32'(dac_powered), 32'hFF);
    clrb = 1'b1;
    @(posedge clk); #1;
    frame(mk(4'h4, 4'hF, 16'h0000), 24);
    send(mk(4'h3, 4'd4, 16'h2468), 24);
    clrb = 1'b0;
    apply(sr_m, 24);
    for (int c = 0; c < 8; c++) begin in_m[c] = '0; dac_m[c] = '0; end
    close(1'b1);
    clrb = 1'b1;
    frame(mk(4'h1, 4'd4, 16'h0000), 24);
    send(mk(4'h3, 4'd0, 16'h1111), 10);
    rstn = 1'b0;
    #2;
    mreset();
    check_regs();
    chk("mid_rst_sdo", 32'(sdo), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    frame(mk(4'h3, 4'd7, 16'h7E57), 24);
    for (int k = 0; k < 40; k++) begin
      rc = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      rn = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 28) : 24;
      frame({$urandom_range(0, 255), rc, ra, 16'($urandom)}, rn);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
